// File: rtl/fnd_scan_driver_if.sv
// rtl/fnd_scan_driver_if.sv - digit capture inputs and segment/common outputs of the FND scan driver
interface fnd_scan_driver_if;
    logic [3:0] iDec_H;
    logic [3:0] iDec_L;
    logic       iUpdate;
    logic [6:0] oSeg;
    logic       oDp;
    logic [1:0] oCom;
    logic       oFrame;

    modport master (
        output iDec_H, iDec_L, iUpdate,
        input  oSeg, oDp, oCom, oFrame
    );

    modport slave (
        input  iDec_H, iDec_L, iUpdate,
        output oSeg, oDp, oCom, oFrame
    );
endinterface

// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - two-digit multiplexed 7-segment scan driver with blanking; FND_LEAD_ZERO_BLANK_EN blanks a zero tens digit
module fnd_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_DIV = 500
) (
    input  logic              iClk,
    input  logic              iRsn,
    fnd_scan_driver_if.slave  bus
);
    localparam int MAX_DIV = (SCAN_DIV > BLANK_DIV) ? SCAN_DIV : BLANK_DIV;
    localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_DIV - 1);

    typedef enum logic [1:0] {
        DIG_L    = 2'd0,
        BLANK_LH = 2'd1,
        DIG_H    = 2'd2,
        BLANK_HL = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    shadow_h_q, shadow_h_d;
    logic [3:0]    shadow_l_q, shadow_l_d;
    logic [3:0]    active_h_q, active_h_d;
    logic [3:0]    active_l_q, active_l_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    com_q, com_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;
    logic          dwell_last;
    logic          frame_start;

    function automatic logic [6:0] encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        shadow_h_d  = shadow_h_q;
        shadow_l_d  = shadow_l_q;
        active_h_d  = active_h_q;
        active_l_d  = active_l_q;
        seg_d       = 7'b1111111;
        com_d       = 2'b11;
        dp_d        = 1'b1;

        if (state_q == DIG_L || state_q == DIG_H) begin
            dwell_last = (cnt_q == SCAN_LAST);
        end else begin
            dwell_last = (cnt_q == BLANK_LAST);
        end
        frame_start = dwell_last && (state_q == BLANK_HL);

        if (dwell_last) begin
            cnt_d = '0;
            case (state_q)
                DIG_L:    state_d = BLANK_LH;
                BLANK_LH: state_d = DIG_H;
                DIG_H:    state_d = BLANK_HL;
                default:  state_d = DIG_L;
            endcase
        end

        if (bus.iUpdate) begin
            shadow_h_d = bus.iDec_H;
            shadow_l_d = bus.iDec_L;
        end

        // The old shadow is taken here, so a capture on this very edge waits a frame.
        if (frame_start) begin
            active_h_d = shadow_h_q;
            active_l_d = shadow_l_q;
        end

        frame_d = frame_start;

        // Outputs are decoded from the next state so they switch with it.
        case (state_d)
            DIG_L: begin
                com_d = 2'b10;
                seg_d = encode(active_l_d);
            end
            DIG_H: begin
                com_d = 2'b01;
`ifdef FND_LEAD_ZERO_BLANK_EN
                seg_d = (active_h_d == 4'd0) ? 7'b1111111 : encode(active_h_d);
`else
                seg_d = encode(active_h_d);
`endif
            end
            default: begin
                com_d = 2'b11;
                seg_d = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q    <= BLANK_HL;
            cnt_q      <= '0;
            shadow_h_q <= 4'd0;
            shadow_l_q <= 4'd0;
            active_h_q <= 4'd0;
            active_l_q <= 4'd0;
            seg_q      <= 7'b1111111;
            com_q      <= 2'b11;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_h_q <= shadow_h_d;
            shadow_l_q <= shadow_l_d;
            active_h_q <= active_h_d;
            active_l_q <= active_l_d;
            seg_q      <= seg_d;
            com_q      <= com_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.oSeg   = seg_q;
    assign bus.oCom   = com_q;
    assign bus.oDp    = dp_q;
    assign bus.oFrame = frame_q;
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb/tb_fnd_scan_driver.sv - scoreboard bench for fnd_scan_driver with SCAN_DIV=4, BLANK_DIV=2
module tb_fnd_scan_driver;
    logic iClk;
    logic iRsn;
    int   n_cmp;
    int   n_err;

    fnd_scan_driver_if bus ();

    fnd_scan_driver #(.SCAN_DIV(4), .BLANK_DIV(2)) dut (
        .iClk (iClk),
        .iRsn (iRsn),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [1:0] com;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    exp_t sb_q[$];

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] ref_tens(input int d);
`ifdef FND_LEAD_ZERO_BLANK_EN
        if (d == 0) return 7'b1111111;
`endif
        return ref_seg(d);
    endfunction

    function automatic void push_blank(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back({2'b11, 7'b1111111, 1'b0});
    endfunction

    function automatic void push_frame(input int l, input int h);
        for (int i = 0; i < 4; i++) sb_q.push_back({2'b10, ref_seg(l), (i == 0)});
        push_blank(2);
        for (int i = 0; i < 4; i++) sb_q.push_back({2'b01, ref_tens(h), 1'b0});
        push_blank(2);
    endfunction

    always @(negedge iClk) begin
        n_cmp++;
        if (bus.oCom === 2'b00) begin
            n_err++;
            $display("FAIL both_digits_on t=%0t oCom=%b required not 00", $time, bus.oCom);
        end
    end

    task automatic do_reset();
        iRsn = 1'b0;
        repeat (2) @(negedge iClk);
        iRsn = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        int   k;
        #2 iRsn = 1'b0;
        #1;
        n_cmp++;
        if (bus.oCom !== 2'b11) begin n_err++; $display("FAIL reset_com got=%b exp=11", bus.oCom); end
        n_cmp++;
        if (bus.oSeg !== 7'b1111111) begin n_err++; $display("FAIL reset_seg got=%b exp=1111111", bus.oSeg); end
        n_cmp++;
        if (bus.oDp !== 1'b1) begin n_err++; $display("FAIL reset_dp got=%b exp=1", bus.oDp); end
        n_cmp++;
        if (bus.oFrame !== 1'b0) begin n_err++; $display("FAIL reset_frame got=%b exp=0", bus.oFrame); end
        repeat (2) @(negedge iClk);
        iRsn = 1'b1;
        push_blank(1);
        push_frame(0, 0);
        push_frame(0, 0);
        k = 0;
        while (sb_q.size() > 0) begin
            @(posedge iClk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.oCom, bus.oSeg, bus.oFrame, bus.oDp} !== {e.com, e.seg, e.frame, 1'b1}) begin
                n_err++;
                $display("FAIL reset_seq cyc=%0d got com=%b seg=%b frame=%b dp=%b exp com=%b seg=%b frame=%b dp=1",
                         k, bus.oCom, bus.oSeg, bus.oFrame, bus.oDp, e.com, e.seg, e.frame);
            end
            k++;
        end
    endtask

    task automatic test_update_mid();
        exp_t e;
        int   k;
        do_reset();
        push_blank(1);
        push_frame(0, 0);
        push_frame(5, 2);
        k = 0;
        while (sb_q.size() > 0) begin
            @(posedge iClk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.oCom, bus.oSeg, bus.oFrame, bus.oDp} !== {e.com, e.seg, e.frame, 1'b1}) begin
                n_err++;
                $display("FAIL update_mid cyc=%0d got com=%b seg=%b frame=%b exp com=%b seg=%b frame=%b",
                         k, bus.oCom, bus.oSeg, bus.oFrame, e.com, e.seg, e.frame);
            end
            bus.iUpdate = (k == 9);
            bus.iDec_H  = 4'd2;
            bus.iDec_L  = 4'd5;
            k++;
        end
        bus.iUpdate = 1'b0;
    endtask

    task automatic test_update_edge();
        exp_t e;
        int   k;
        do_reset();
        push_blank(1);
        push_frame(0, 0);
        push_frame(8, 6);
        push_frame(7, 3);
        k = 0;
        while (sb_q.size() > 0) begin
            @(posedge iClk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.oCom, bus.oSeg, bus.oFrame, bus.oDp} !== {e.com, e.seg, e.frame, 1'b1}) begin
                n_err++;
                $display("FAIL update_edge cyc=%0d got com=%b seg=%b frame=%b exp com=%b seg=%b frame=%b",
                         k, bus.oCom, bus.oSeg, bus.oFrame, e.com, e.seg, e.frame);
            end
            bus.iUpdate = (k == 3) || (k == 12);
            bus.iDec_H  = (k == 3) ? 4'd6 : 4'd3;
            bus.iDec_L  = (k == 3) ? 4'd8 : 4'd7;
            k++;
        end
        bus.iUpdate = 1'b0;
    endtask

    task automatic test_lead_zero();
        exp_t e;
        int   k;
        do_reset();
        push_blank(1);
        push_frame(0, 0);
        push_frame(4, 0);
        k = 0;
        while (sb_q.size() > 0) begin
            @(posedge iClk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.oCom, bus.oSeg, bus.oFrame, bus.oDp} !== {e.com, e.seg, e.frame, 1'b1}) begin
                n_err++;
                $display("FAIL lead_zero cyc=%0d got com=%b seg=%b frame=%b exp com=%b seg=%b frame=%b",
                         k, bus.oCom, bus.oSeg, bus.oFrame, e.com, e.seg, e.frame);
            end
            bus.iUpdate = (k == 3);
            bus.iDec_H  = 4'd0;
            bus.iDec_L  = 4'd4;
            k++;
        end
        bus.iUpdate = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   k;
        int   f;
        do_reset();
        push_blank(1);
        push_frame(0, 0);
        for (int d = 0; d < 16; d++) push_frame(d, 15 - d);
        k = 0;
        while (sb_q.size() > 0) begin
            @(posedge iClk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.oCom, bus.oSeg, bus.oFrame, bus.oDp} !== {e.com, e.seg, e.frame, 1'b1}) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d got com=%b seg=%b frame=%b exp com=%b seg=%b frame=%b",
                         k, bus.oCom, bus.oSeg, bus.oFrame, e.com, e.seg, e.frame);
            end
            f = (k - 6) / 12;
            bus.iUpdate = (k >= 6) && (k <= 186) && ((k % 12) == 6);
            bus.iDec_L  = 4'(f);
            bus.iDec_H  = 4'(15 - f);
            k++;
        end
        bus.iUpdate = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   k;
        bus.iDec_H  = 4'd9;
        bus.iDec_L  = 4'd9;
        bus.iUpdate = 1'b1;
        do_reset();
        bus.iUpdate = 1'b0;
        repeat (10) @(posedge iClk);
        #1;
        n_cmp++;
        if (bus.oCom !== 2'b01) begin n_err++; $display("FAIL mid_dig_h_com got=%b exp=01", bus.oCom); end
        #3 iRsn = 1'b0;
        #1;
        n_cmp++;
        if (bus.oCom !== 2'b11) begin n_err++; $display("FAIL async_reset_com got=%b exp=11", bus.oCom); end
        n_cmp++;
        if (bus.oSeg !== 7'b1111111) begin n_err++; $display("FAIL async_reset_seg got=%b exp=1111111", bus.oSeg); end
        n_cmp++;
        if (bus.oFrame !== 1'b0) begin n_err++; $display("FAIL async_reset_frame got=%b exp=0", bus.oFrame); end
        repeat (2) @(negedge iClk);
        iRsn = 1'b1;
        push_blank(1);
        push_frame(0, 0);
        k = 0;
        while (sb_q.size() > 0) begin
            @(posedge iClk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if ({bus.oCom, bus.oSeg, bus.oFrame, bus.oDp} !== {e.com, e.seg, e.frame, 1'b1}) begin
                n_err++;
                $display("FAIL reset_mid_seq cyc=%0d got com=%b seg=%b frame=%b exp com=%b seg=%b frame=%b",
                         k, bus.oCom, bus.oSeg, bus.oFrame, e.com, e.seg, e.frame);
            end
            k++;
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        iRsn        = 1'b1;
        bus.iDec_H  = 4'd0;
        bus.iDec_L  = 4'd0;
        bus.iUpdate = 1'b0;
        test_reset();
        test_update_mid();
        test_update_edge();
        test_lead_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
